load_scoreboard: RTL and testbench

- Producer-side companion to the operand forwarding path.
- Tracks destination registers of in-flight loads whose data cannot yet be forwarded.
- Stalls decode/issue when a source operand, or a WAW destination, hits a pending load.
- Clears entries when the memory response writes back; sits between decode and execute, beside the forwarding mux.

---
 rtl/load_scoreboard.sv | 114 +++++++++++
 tb/tb_load_scoreboard.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/load_scoreboard.sv
// Pending-load scoreboard: tracks destinations of in-flight loads and stalls
// decode on RAW/WAW hits or when the outstanding-load budget is exhausted.
module load_scoreboard #(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_uses_rs1,
    input  logic             issue_uses_rs2,
    input  logic [4:0]       issue_rd,
    input  logic             issue_is_load,
    input  logic             flush,
    input  logic             rsp_valid,
    input  logic [4:0]       rsp_rd,
    output logic             stall,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] pending_count,
    output logic             rsp_err,
    output logic [31:0]      stall_cycles
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOADS);

    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      stall_cyc_q, stall_cyc_d;

    logic [31:0] clear_mask;
    logic [31:0] set_mask;
    logic [31:0] eff_busy;
    logic        rsp_hit;
    logic        rsp_x0_dec;
    logic        raw1, raw2, waw, full;
    logic        accept;
    logic        cnt_inc, cnt_dec;

    always_comb begin
        clear_mask = '0;
        if (rsp_valid && rsp_rd != 5'd0)
            clear_mask = 32'd1 << rsp_rd;
    end

    // A response landing this cycle is forwarded, so it already resolves hazards.
    assign eff_busy   = busy_q & ~clear_mask;
    assign rsp_hit    = rsp_valid && (rsp_rd != 5'd0) && busy_q[rsp_rd];
    assign rsp_x0_dec = rsp_valid && (rsp_rd == 5'd0) && (cnt_q != '0);

    assign raw1 = issue_uses_rs1 && (issue_rs1 != 5'd0) && eff_busy[issue_rs1];
    assign raw2 = issue_uses_rs2 && (issue_rs2 != 5'd0) && eff_busy[issue_rs2];
    assign waw  = issue_is_load && (issue_rd != 5'd0) && eff_busy[issue_rd];
    assign full = issue_is_load && (cnt_q == MAX_CNT) && !rsp_hit;

    assign stall  = issue_valid && !flush && (raw1 || raw2 || waw || full);
    assign accept = issue_valid && !flush && !stall;

    always_comb begin
        set_mask = '0;
        if (accept && issue_is_load && issue_rd != 5'd0)
            set_mask = 32'd1 << issue_rd;
    end

    assign cnt_inc = accept && issue_is_load;
    assign cnt_dec = rsp_hit || rsp_x0_dec;

    always_comb begin
        // Set after clear: a same-register reissue keeps the bit busy.
        busy_d    = (busy_q & ~clear_mask) | set_mask;
        busy_d[0] = 1'b0;

        cnt_d = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q;
        if (rsp_valid) begin
            if (rsp_rd != 5'd0 && !busy_q[rsp_rd])
                err_d = 1'b1;
            if (rsp_rd == 5'd0 && cnt_q == '0)
                err_d = 1'b1;
        end

        stall_cyc_d = stall_cyc_q;
        if (stall && stall_cyc_q != 32'hFFFF_FFFF)
            stall_cyc_d = stall_cyc_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            stall_cyc_q <= '0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign busy_mask     = busy_q;
    assign pending_count = cnt_q;
    assign rsp_err       = err_q;
    assign stall_cycles  = stall_cyc_q;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard: hazards, capacity, same-cycle
// set/clear, flush, error flag and reset dominance.
module tb_load_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_uses_rs1, issue_uses_rs2, issue_is_load;
    logic        flush;
    logic        rsp_valid;
    logic [4:0]  rsp_rd;
    logic        stall;
    logic [31:0] busy_mask;
    logic [2:0]  pending_count;
    logic        rsp_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    load_scoreboard #(.MAX_LOADS(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
        .issue_rd(issue_rd), .issue_is_load(issue_is_load), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_rd(rsp_rd),
        .stall(stall), .busy_mask(busy_mask), .pending_count(pending_count),
        .rsp_err(rsp_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_uses_rs1 = 0; issue_uses_rs2 = 0; issue_is_load = 0;
        flush = 0; rsp_valid = 0; rsp_rd = 0;
    endtask

    task automatic load(input logic [4:0] rd);
        issue_valid = 1; issue_is_load = 1; issue_rd = rd;
        issue_uses_rs1 = 0; issue_uses_rs2 = 0;
    endtask

    task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = 1; issue_is_load = 0; issue_rd = 5'd1;
        issue_rs1 = rs1; issue_uses_rs1 = 1;
        issue_rs2 = rs2; issue_uses_rs2 = 1;
    endtask

    task automatic rsp(input logic [4:0] rd);
        rsp_valid = 1; rsp_rd = rd;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        tick(); tick();
        rst = 0; #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want %h", busy_mask, 32'h0); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pending_count); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stallcyc: got %0d want 0", stall_cycles); end
    endtask

    task automatic test_raw();
        idle(); load(5'd5); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_load_stall: got %b want 0", stall); end
        tick();
        checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL raw_busy_set: got %h want %h", busy_mask, 32'h20); end
        idle(); alu(5'd5, 5'd0); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c1: got %b want 1", stall); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c2: got %b want 1", stall); end
        tick();
        rsp(5'd5); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_rsp_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL raw_busy_clr: got %h want 0", busy_mask); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL raw_count: got %0d want 0", pending_count); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL raw_stallcyc: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_full();
        idle(); load(5'd3); tick();
        load(5'd4); tick();
        checks++; if (pending_count !== 3'd2) begin errors++; $display("FAIL full_count2: got %0d want 2", pending_count); end
        checks++; if (busy_mask !== 32'h18) begin errors++; $display("FAIL full_busy: got %h want %h", busy_mask, 32'h18); end
        load(5'd6); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
        tick();
        rsp(5'd3); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_rsp_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (pending_count !== 3'd2) begin errors++; $display("FAIL full_count_keep: got %0d want 2", pending_count); end
        checks++; if (busy_mask !== 32'h50) begin errors++; $display("FAIL full_busy_46: got %h want %h", busy_mask, 32'h50); end
        checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL full_stallcyc: got %0d want 3", stall_cycles); end
        rsp(5'd4); tick(); rsp(5'd6); tick(); idle(); #1;
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", pending_count); end
    endtask

    task automatic test_x0_load();
        idle(); load(5'd0); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL x0_count: got %0d want 1", pending_count); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
        rsp(5'd0); tick(); idle(); #1;
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL x0_rsp_count: got %0d want 0", pending_count); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL x0_rsp_err: got %b want 0", rsp_err); end
    endtask

    task automatic test_same_reg();
        idle(); load(5'd7); tick();
        load(5'd7); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", stall); end
        tick();
        rsp(5'd7); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL same_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL same_busy: got %h want %h", busy_mask, 32'h80); end
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL same_count: got %0d want 1", pending_count); end
        rsp(5'd7); tick(); idle(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL same_drain: got %h want 0", busy_mask); end
    endtask

    task automatic test_flush_err();
        idle(); load(5'd5); tick();
        alu(5'd5, 5'd5); flush = 1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL flush_busy: got %h want %h", busy_mask, 32'h20); end
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL flush_count: got %0d want 1", pending_count); end
        checks++; if (stall_cycles !== 32'd4) begin errors++; $display("FAIL flush_stallcyc: got %0d want 4", stall_cycles); end
        rsp(5'd9); tick(); idle(); #1;
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", rsp_err); end
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL err_count: got %0d want 1", pending_count); end
        rsp(5'd5); tick(); idle(); tick();
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", rsp_err); end
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL err_drain: got %h want 0", busy_mask); end
    endtask

    task automatic test_rst_dominates();
        idle(); load(5'd2); tick();
        load(5'd8); tick();
        alu(5'd0, 5'd8); #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
        rst = 1; rsp(5'd2); tick();
        rst = 0; idle(); #1;
        checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL rst_busy: got %h want 0", busy_mask); end
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", pending_count); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", rsp_err); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stallcyc: got %0d want 0", stall_cycles); end
        load(5'd2); #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_reload_stall: got %b want 0", stall); end
        tick(); idle(); #1;
        checks++; if (busy_mask !== 32'h4) begin errors++; $display("FAIL rst_reload_busy: got %h want %h", busy_mask, 32'h4); end
        checks++; if (pending_count !== 3'd1) begin errors++; $display("FAIL rst_reload_count: got %0d want 1", pending_count); end
    endtask

    task automatic test_underflow();
        idle(); rsp(5'd2); tick(); idle(); #1;
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL uf_drain: got %0d want 0", pending_count); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL uf_no_err: got %b want 0", rsp_err); end
        rsp(5'd0); tick(); idle(); #1;
        checks++; if (pending_count !== 3'd0) begin errors++; $display("FAIL uf_no_wrap: got %0d want 0", pending_count); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL uf_err: got %b want 1", rsp_err); end
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_raw();
        test_full();
        test_x0_load();
        test_same_reg();
        test_flush_err();
        test_rst_dominates();
        test_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
